inst_fetch_resp: RTL

//  Responder side of the PC-stage fetch interface: accepts {pc, except} fetch requests, buffers them,

---
 rtl/inst_fetch_resp_if.sv | 25 ++
 rtl/inst_fetch_resp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp_if.sv
// Fetch handshake bundle: {pc, except} requests from the PC stage and
// {pc, inst, except} responses towards IF/ID, each under valid/ready.
interface inst_fetch_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [6:0]  req_except;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_inst;
    logic [6:0]  resp_except;

    // Requester/consumer side: issues fetch requests and accepts responses
    modport master (
        output req_valid, req_pc, req_except, resp_ready,
        input  req_ready, resp_valid, resp_pc, resp_inst, resp_except
    );

    // Responder side: the fetch block that owns instruction memory
    modport slave (
        input  req_valid, req_pc, req_except, resp_ready,
        output req_ready, resp_valid, resp_pc, resp_inst, resp_except
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// Fetch responder: buffers PC-stage requests in a small FIFO, serves them one at
// a time against a 1-cycle synchronous instruction ROM and returns the words.
// Address-error (AdEL) requests skip the ROM and come back with inst = 0.
// Optional macro IFR_STAT_EN adds response and consumer-stall counters.
module inst_fetch_resp #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    inst_fetch_resp_if.slave  bus,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rdata
`ifdef IFR_STAT_EN
    ,
    output logic [31:0]       stat_resp_cnt,
    output logic [31:0]       stat_wait_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_INC = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, STALL, READ, CAPT, DONE} state_t;

    logic [31:0]       bufPc_q  [DEPTH];
    logic [6:0]        bufExc_q [DEPTH];
    logic [PTR_W:0]    wrPtr_q, rdPtr_q;
    logic              bufFull, bufEmpty;
    logic              push, pop, bubble;
    logic [31:0]       headPc;
    logic [6:0]        headExc;
    logic              headAdel;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       workPc_q;
    logic [6:0]        workExc_q;
    logic              workAdel_q;
    logic [ADDR_W-1:0] lastAddr_q;

    logic              respValid_q;
    logic [31:0]       respPc_q, respInst_q;
    logic [6:0]        respExc_q;
    logic              respHandshake;

    // Pointers carry an extra wrap bit, so full is "same slot, different lap"
    assign bufEmpty = (wrPtr_q == rdPtr_q);
    assign bufFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                      (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

    // No bypass: a full buffer refuses a push even if it pops in the same cycle
    assign bus.req_ready = resetn && !bufFull && !flush;
    assign push          = bus.req_valid && bus.req_ready;
    assign bubble        = (bus.req_pc == 32'h0) && (bus.req_except == 7'h0);

    assign headPc   = bufPc_q[rdPtr_q[PTR_W-1:0]];
    assign headExc  = bufExc_q[rdPtr_q[PTR_W-1:0]];
    assign headAdel = headExc[1] | (|headPc[1:0]);

    assign respHandshake = respValid_q && bus.resp_ready && !flush;

    // Request storage; contents need no reset because the pointers qualify them
    always_ff @(posedge clk) begin
        if (push && !bubble) begin
            bufPc_q[wrPtr_q[PTR_W-1:0]]  <= bus.req_pc;
            bufExc_q[wrPtr_q[PTR_W-1:0]] <= bus.req_except;
        end
    end

    // Buffer pointers; flush empties the buffer, bubbles are accepted but never stored
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push && !bubble) wrPtr_q <= wrPtr_q + PTR_INC;
            if (pop)             rdPtr_q <= rdPtr_q + PTR_INC;
        end
    end

    // Sequencer next state: AdEL requests skip the ROM and go straight to capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        rom_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bufEmpty && !respValid_q) begin
                    pop = 1'b1;
                    if (headAdel) begin
                        state_d = CAPT;
                    end else if (WAIT == 0) begin
                        state_d = READ;
                    end else begin
                        state_d = STALL;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            STALL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = READ;
            end
            READ: begin
                rom_en  = 1'b1;
                state_d = CAPT;
            end
            CAPT: state_d = DONE;
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
            rom_en  = 1'b0;
        end
    end

    // Sequencer state, working request and the last address driven to the ROM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            workPc_q   <= '0;
            workExc_q  <= '0;
            workAdel_q <= 1'b0;
            lastAddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                workPc_q   <= headPc;
                workExc_q  <= headExc;
                workAdel_q <= headAdel;
            end
            if (rom_en) lastAddr_q <= workPc_q[ADDR_W+1:2];
        end
    end

    assign rom_addr = rom_en ? workPc_q[ADDR_W+1:2] : lastAddr_q;

    // Response register: loaded from the ROM in CAPT, held until consumed or flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            respValid_q <= 1'b0;
            respPc_q    <= '0;
            respInst_q  <= '0;
            respExc_q   <= '0;
        end else if (flush) begin
            respValid_q <= 1'b0;
        end else if (state_q == CAPT) begin
            respValid_q <= 1'b1;
            respPc_q    <= workPc_q;
            respInst_q  <= workAdel_q ? 32'h0 : rom_rdata;
            respExc_q   <= {workExc_q[6:2], workAdel_q, workExc_q[0]};
        end else if (respHandshake) begin
            respValid_q <= 1'b0;
        end
    end

    assign bus.resp_valid  = respValid_q;
    assign bus.resp_pc     = respPc_q;
    assign bus.resp_inst   = respInst_q;
    assign bus.resp_except = respExc_q;

`ifdef IFR_STAT_EN
    // Counters for delivered responses and cycles a response waited on the consumer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_resp_cnt <= '0;
            stat_wait_cnt <= '0;
        end else begin
            if (respHandshake)                   stat_resp_cnt <= stat_resp_cnt + 32'd1;
            if (respValid_q && !bus.resp_ready)  stat_wait_cnt <= stat_wait_cnt + 32'd1;
        end
    end
`endif
endmodule
